ins_ram: RTL
============

Name: ins_ram

Overview:
- Instruction memory that sits directly upstream of the CPU core.
- Accepts the core's fetch request (en_ram_in with a 16-bit addr) and returns the 16-bit instruction word with a one-cycle en_ram_out strobe after a fixed, parameterised latency.
- A host-side load port preloads the program image.
- Contents are held in a synchronous register array of 2**ADDR_W words.

Parameters:
- ADDR_W, 8, implemented address bits; depth = 2**ADDR_W words.
- RD_LAT, 1, cycles from request cycle to response cycle; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- en_ram_in  in  1  fetch request from core; sampled each rising edge.
- addr  in  16  fetch address (the core's PC), sampled with en_ram_in.
- en_ram_out  out  1  one-cycle strobe; ins is valid in this cycle.
- ins  out  16  fetched instruction word.
- busy  out  1  request in flight; new requests are ignored while high.
- addr_err  out  1  pulses with en_ram_out when the fetched addr was out of range.
- par_err  out  1  pulses with en_ram_out on a parity mismatch; tied 0 without the macro.
- ld_we  in  1  host write enable.
- ld_addr  in  ADDR_W  host write address.
- ld_data  in  16  host write data.

Behaviour:
- Reset (rst=0, asynchronous):
  - en_ram_out=0, ins=16'h0000, busy=0, addr_err=0, par_err=0.
  - FSM returns to IDLE and the latency counter goes to 0.
  - Memory array is not cleared.
- Reset mid-operation: the pending request is discarded; no en_ram_out follows reset release.
- FSM has two states, IDLE and WAIT. busy is registered and equals (state==WAIT).
- Accept rule:
  - A request is accepted on the rising edge that ends cycle n if en_ram_in=1 and busy=0 in cycle n.
  - The response cycle of a prior request also has busy=0, so back-to-back acceptance is allowed.
  - en_ram_in while busy=1 is ignored; there is no queueing.
- Read capture:
  - At the accept edge, mem[addr[ADDR_W-1:0]] is read into a holding register, together with the range flag.
  - This is read-before-write: a same-edge ld_we to the same location leaves the fetch with the old word.
- Timing:
  - Request in cycle n gives en_ram_out=1 and a valid ins in cycle n+RD_LAT.
  - busy=1 in cycles n+1 .. n+RD_LAT-1. For RD_LAT=1, busy never asserts and one fetch per cycle is sustained.
  - In WAIT the counter loads RD_LAT-2 on entry and decrements. On reaching 0 the FSM returns to IDLE and en_ram_out pulses on the next edge.
- ins holds its last value between responses. en_ram_out is exactly one cycle wide per accepted request.
- Range check:
  - If addr[15:ADDR_W] != 0, the response carries ins=16'h0000 and addr_err=1 in the en_ram_out cycle.
  - Timing is unchanged.
  - For ADDR_W=16 the check is disabled.
- Load port:
  - ld_we=1 writes ld_data to mem[ld_addr] at the edge, independent of the FSM.
  - It is legal while busy=1; the in-flight fetch is unaffected.
- RD_LAT outside 1..4 is a configuration error, flagged by an elaboration-time check.

Optional Feature:
- Macro: INS_RAM_PARITY_EN.
- Defined:
  - Each word stores a 17th bit holding the even parity of ld_data, computed at load time.
  - At the accept edge, parity of the read word is recomputed and compared.
  - On a mismatch, the response gives ins=16'h0000 and par_err=1 with en_ram_out.
  - An out-of-range address takes priority: addr_err=1, par_err=0.
- Not defined: no parity storage; par_err is a constant 0.

Test Plan:
- Reset, then load mem[0..3]=16'h1234,16'hA5A5,16'h0F0F,16'hFFFF. RD_LAT=1, en_ram_in=1 in four consecutive cycles with addr 0..3 -> en_ram_out high in 4 consecutive cycles with ins in that order, busy stays 0.
- RD_LAT=3, request addr=2 in cycle n with en_ram_in held high -> busy=1 in n+1..n+2 (requests ignored), en_ram_out=1 with ins=16'h0F0F in n+3, next request accepted in n+3.
- ld_we to addr 1 with data 16'hBEEF on the same edge as a fetch of addr 1 -> response returns 16'hA5A5; a following fetch returns 16'hBEEF.
- Fetch addr=16'h0100 with ADDR_W=8 -> ins=16'h0000, addr_err=1 for one cycle together with en_ram_out.
- RD_LAT=4, assert rst=0 in cycle n+2 after an accept -> outputs zero immediately; after release, no en_ram_out occurs until a new request.
- With INS_RAM_PARITY_EN, force-corrupt the stored parity bit of addr 3 and fetch it -> ins=16'h0000, par_err=1, addr_err=0.

Source files
------------

// File: rtl/ins_ram.sv
// ins_ram: instruction memory feeding the core, fixed RD_LAT fetch latency.
// Ports: clk, rst (async, active-low). Fetch inputs: en_ram_in, addr.
// Fetch outputs: en_ram_out, ins, busy, addr_err, par_err.
// Host load port: ld_we, ld_addr, ld_data.
// Optional macro INS_RAM_PARITY_EN adds a stored even-parity bit per word.
module ins_ram #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_ram_in,
    input  logic [15:0]       addr,
    output logic              en_ram_out,
    output logic [15:0]       ins,
    output logic              busy,
    output logic              addr_err,
    output logic              par_err,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [15:0]       ld_data
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef INS_RAM_PARITY_EN
    localparam int MEM_W = 17;
`else
    localparam int MEM_W = 16;
`endif
    localparam logic [1:0] CNT_INIT =
        (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_lat_chk
        $error("ins_ram: RD_LAT must be within 1..4");
    end

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_cnt;
    logic [1:0]       w_cnt_nxt;
    logic             w_accept;
    logic             w_fire_now;
    logic             w_fire_hold;
    logic             w_load_hold;
    logic [MEM_W-1:0] r_mem [DEPTH];
    logic [MEM_W-1:0] w_rd_word;
    logic             w_oor;
    logic             w_rd_perr;
    logic [15:0]      w_rd_ins;
    logic [15:0]      r_hold_ins;
    logic             r_hold_aerr;
    logic             r_hold_perr;
    logic             r_par_err;

    // Host load port, free-running relative to the fetch FSM.
    always_ff @(posedge clk) begin
        if (ld_we) begin
`ifdef INS_RAM_PARITY_EN
            r_mem[ld_addr] <= {^ld_data, ld_data};
`else
            r_mem[ld_addr] <= ld_data;
`endif
        end
    end

    assign w_rd_word = r_mem[addr[ADDR_W-1:0]];

    if (ADDR_W < 16) begin : g_rng
        assign w_oor = |addr[15:ADDR_W];
    end else begin : g_norng
        assign w_oor = 1'b0;
    end

    // Range error wins over parity error.
`ifdef INS_RAM_PARITY_EN
    assign w_rd_perr = !w_oor &&
        ((^w_rd_word[15:0]) != w_rd_word[16]);
`else
    assign w_rd_perr = 1'b0;
`endif

    assign w_rd_ins = (w_oor || w_rd_perr) ? 16'h0000
                                           : w_rd_word[15:0];

    assign busy     = (r_state == S_WAIT);
    assign w_accept = en_ram_in && !busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // RD_LAT=1 answers straight off the accept edge; longer
    // latencies park the word in the hold register while counting.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fire_now  = 1'b0;
        w_fire_hold = 1'b0;
        w_load_hold = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (RD_LAT == 1) begin
                        w_fire_now = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_INIT;
                        w_load_hold = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_state_nxt = S_IDLE;
                    w_fire_hold = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_ins  <= 16'h0000;
            r_hold_aerr <= 1'b0;
            r_hold_perr <= 1'b0;
        end else if (w_load_hold) begin
            r_hold_ins  <= w_rd_ins;
            r_hold_aerr <= w_oor;
            r_hold_perr <= w_rd_perr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_ram_out <= 1'b0;
            ins        <= 16'h0000;
            addr_err   <= 1'b0;
            r_par_err  <= 1'b0;
        end else begin
            en_ram_out <= w_fire_now || w_fire_hold;
            addr_err   <= 1'b0;
            r_par_err  <= 1'b0;
            if (w_fire_now) begin
                ins       <= w_rd_ins;
                addr_err  <= w_oor;
                r_par_err <= w_rd_perr;
            end else if (w_fire_hold) begin
                ins       <= r_hold_ins;
                addr_err  <= r_hold_aerr;
                r_par_err <= r_hold_perr;
            end
        end
    end

`ifdef INS_RAM_PARITY_EN
    assign par_err = r_par_err;
`else
    assign par_err = 1'b0;
`endif

endmodule
